// File: rtl/mmio_tile_link_responder.sv
// mmio_tile_link_responder: TileLink MMIO slave terminating the outer acquire channel
// with grants, backed by a 64-bit-word scratch register array.
module mmio_tile_link_responder #(
    parameter int ADDR_BITS  = 6,
    parameter int MANAGER_ID = 0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        io_acquire_ready,
    input  logic        io_acquire_valid,
    input  logic [25:0] io_acquire_bits_addr_block,
    input  logic [1:0]  io_acquire_bits_client_xact_id,
    input  logic [2:0]  io_acquire_bits_addr_beat,
    input  logic        io_acquire_bits_is_builtin_type,
    input  logic [2:0]  io_acquire_bits_a_type,
    input  logic [11:0] io_acquire_bits_union,
    input  logic [63:0] io_acquire_bits_data,
    input  logic        io_grant_ready,
    output logic        io_grant_valid,
    output logic [2:0]  io_grant_bits_addr_beat,
    output logic [1:0]  io_grant_bits_client_xact_id,
    output logic        io_grant_bits_manager_xact_id,
    output logic        io_grant_bits_is_builtin_type,
    output logic [3:0]  io_grant_bits_g_type,
    output logic [63:0] io_grant_bits_data
);
    localparam int BB = ADDR_BITS - 3;
    localparam logic [1:0] IDLE = 2'd0, PUT_BLK = 2'd1, GRANT = 2'd2, GET_BLK = 2'd3;

    logic [1:0]           state;
    logic [BB-1:0]        blk;
    logic [63:0]          mem [2**ADDR_BITS];
    logic                 acq_fire, grant_fire, wr_en, is_put;
    logic [BB-1:0]        acq_blk, cur_blk;
    logic [2:0]           a_type, a_beat, nxt_beat;
    logic [7:0]           mask;
    logic [ADDR_BITS-1:0] wr_idx, rd_idx;
    logic [63:0]          rd_data;
    logic [1:0]           idle_next;
    logic [3:0]           idle_type;
    logic [2:0]           idle_beat;
    logic [63:0]          idle_data;
    logic                 unused;

    assign io_acquire_ready = state == IDLE || state == PUT_BLK;
    assign io_grant_valid   = state == GRANT || state == GET_BLK;
    assign acq_fire   = io_acquire_valid & io_acquire_ready;
    assign grant_fire = io_grant_valid & io_grant_ready;
    assign a_type   = io_acquire_bits_a_type;
    assign a_beat   = io_acquire_bits_addr_beat;
    assign mask     = io_acquire_bits_union[8:1];
    assign nxt_beat = io_grant_bits_addr_beat + 3'd1;
    // upper block bits alias onto the same words
    assign acq_blk  = io_acquire_bits_addr_block[BB-1:0];
    assign cur_blk  = state == IDLE ? acq_blk : blk;
    assign is_put   = io_acquire_bits_is_builtin_type && (a_type == 3'd2 || a_type == 3'd3);
    assign wr_en    = acq_fire && (state == PUT_BLK || is_put);
    assign wr_idx   = {cur_blk, a_beat};
    assign rd_idx   = state == GET_BLK ? {blk, nxt_beat} : {acq_blk, a_type == 3'd1 ? 3'd0 : a_beat};
    assign rd_data  = mem[rd_idx];
    assign unused   = &{1'b0, io_acquire_bits_addr_block[25:BB], io_acquire_bits_union[11:9],
                        io_acquire_bits_union[0]};

    always_comb begin
        idle_next = GRANT;
        idle_type = 4'd4;
        idle_beat = 3'd0;
        idle_data = '0;
        if (io_acquire_bits_is_builtin_type) begin
            case (a_type)
                3'd0: begin
                    idle_beat = a_beat;
                    idle_data = rd_data;
                end
                3'd1: begin
                    idle_type = 4'd5;
                    idle_data = rd_data;
                    idle_next = GET_BLK;
                end
                3'd2, 3'd4: idle_type = 4'd3;
                3'd3: begin
                    idle_type = 4'd3;
                    idle_next = a_beat == 3'd7 ? GRANT : PUT_BLK;
                end
                3'd5, 3'd6: idle_type = 4'd1;
                default: idle_type = 4'd4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            for (int i = 0; i < 8; i++)
                if (mask[i]) mem[wr_idx][i*8 +: 8] <= io_acquire_bits_data[i*8 +: 8];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                         <= IDLE;
            blk                           <= '0;
            io_grant_bits_client_xact_id  <= '0;
            io_grant_bits_addr_beat       <= '0;
            io_grant_bits_g_type          <= '0;
            io_grant_bits_data            <= '0;
            io_grant_bits_is_builtin_type <= 1'b0;
            io_grant_bits_manager_xact_id <= 1'b0;
        end else begin
            case (state)
                IDLE: if (acq_fire) begin
                    state                         <= idle_next;
                    blk                           <= acq_blk;
                    io_grant_bits_client_xact_id  <= io_acquire_bits_client_xact_id;
                    io_grant_bits_addr_beat       <= idle_beat;
                    io_grant_bits_g_type          <= idle_type;
                    io_grant_bits_data            <= idle_data;
                    io_grant_bits_is_builtin_type <= 1'b1;
                    io_grant_bits_manager_xact_id <= 1'(MANAGER_ID);
                end
                PUT_BLK: if (acq_fire && a_beat == 3'd7) begin
                    state                   <= GRANT;
                    io_grant_bits_addr_beat <= 3'd0;
                    io_grant_bits_g_type    <= 4'd3;
                    io_grant_bits_data      <= '0;
                end
                GRANT: if (grant_fire) state <= IDLE;
                default: if (grant_fire) begin
                    if (io_grant_bits_addr_beat == 3'd7) state <= IDLE;
                    else begin
                        io_grant_bits_addr_beat <= nxt_beat;
                        io_grant_bits_data      <= rd_data;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_tile_link_responder.sv
// tb_mmio_tile_link_responder: randomized self-checking bench against a word-array
// reference model of the MMIO responder.
module tb_mmio_tile_link_responder;
    logic        clk = 0, reset = 0;
    logic        a_ready, a_valid = 0, a_bi = 0, g_ready = 0, g_valid, g_mgr, g_bi;
    logic [25:0] a_blk = 0;
    logic [1:0]  a_id = 0, g_id;
    logic [2:0]  a_beat = 0, a_type = 0, g_beat;
    logic [11:0] a_union = 0;
    logic [63:0] a_data = 0, g_data;
    logic [3:0]  g_type;
    logic [63:0] mem_m [64];
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    mmio_tile_link_responder dut (
        .clk(clk), .reset(reset),
        .io_acquire_ready(a_ready), .io_acquire_valid(a_valid),
        .io_acquire_bits_addr_block(a_blk), .io_acquire_bits_client_xact_id(a_id),
        .io_acquire_bits_addr_beat(a_beat), .io_acquire_bits_is_builtin_type(a_bi),
        .io_acquire_bits_a_type(a_type), .io_acquire_bits_union(a_union),
        .io_acquire_bits_data(a_data), .io_grant_ready(g_ready), .io_grant_valid(g_valid),
        .io_grant_bits_addr_beat(g_beat), .io_grant_bits_client_xact_id(g_id),
        .io_grant_bits_manager_xact_id(g_mgr), .io_grant_bits_is_builtin_type(g_bi),
        .io_grant_bits_g_type(g_type), .io_grant_bits_data(g_data)
    );

    function automatic int idx(input logic [25:0] blk, input logic [2:0] beat);
        return {blk[2:0], beat};
    endfunction

    function automatic void m_put(input int i, input logic [7:0] m, input logic [63:0] d);
        for (int b = 0; b < 8; b++) if (m[b]) mem_m[i][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    // presents one acquire beat from a negedge and returns at the negedge after it fires
    task automatic acq(input logic [25:0] blk, input logic [2:0] beat, input logic [2:0] t,
                       input logic bi, input logic [7:0] m, input logic [63:0] d, input logic [1:0] id);
        int n = 0;
        a_valid = 1; a_blk = blk; a_beat = beat; a_type = t; a_bi = bi;
        a_union = {3'b0, m, 1'b0}; a_data = d; a_id = id;
        while (!a_ready && n < 20) begin @(negedge clk); n++; end
        if (!a_ready) begin
            tests++; fails++;
            $display("FAIL acq_timeout ready=%b required 1", a_ready);
        end
        @(posedge clk); @(negedge clk);
        a_valid = 0;
    endtask

    task automatic take(output logic [2:0] beat, output logic [3:0] gt, output logic [63:0] d,
                        output logic [1:0] id);
        int n = 0;
        while (!g_valid && n < 20) begin @(negedge clk); n++; end
        if (!g_valid) begin
            tests++; fails++;
            $display("FAIL grant_timeout valid=%b required 1", g_valid);
        end
        beat = g_beat; gt = g_type; d = g_data; id = g_id;
        g_ready = 1;
        @(negedge clk);
        g_ready = 0;
    endtask

    task automatic test_reset;
        reset = 0;
        #1;
        tests++;
        if ({g_valid, g_type, g_data, g_beat, g_id} !== 72'd0) begin
            fails++;
            $display("FAIL reset_grant got v=%b t=%h d=%h b=%h id=%h required all 0",
                     g_valid, g_type, g_data, g_beat, g_id);
        end
        @(negedge clk); @(negedge clk);
        reset = 1;
        #1;
        tests++;
        if (a_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b required 1", a_ready); end
        @(negedge clk);
    endtask

    task automatic check_latency(input string name);
        tests++;
        if (g_valid !== 1'b1 || a_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s_latency got valid=%b ready=%b required 1 0", name, g_valid, a_ready);
        end
    endtask

    task automatic test_put_get;
        logic [2:0] b; logic [3:0] t; logic [63:0] d; logic [1:0] id;
        acq(26'd2, 3'd1, 3'd2, 1, 8'hFF, 64'h1122334455667788, 2'd2);
        m_put(idx(2, 1), 8'hFF, 64'h1122334455667788);
        check_latency("put");
        take(b, t, d, id);
        tests++;
        if ({t, id, d} !== {4'd3, 2'd2, 64'd0}) begin
            fails++; $display("FAIL put_ack got t=%0d id=%0d d=%h required 3 2 0", t, id, d);
        end
        acq(26'd2, 3'd1, 3'd0, 1, 8'h00, 64'd0, 2'd1);
        check_latency("get");
        take(b, t, d, id);
        tests++;
        if ({t, b, id, d} !== {4'd4, 3'd1, 2'd1, 64'h1122334455667788}) begin
            fails++; $display("FAIL get1 got t=%0d b=%0d id=%0d d=%h required 4 1 1 1122334455667788", t, b, id, d);
        end
        acq(26'd2, 3'd1, 3'd2, 1, 8'h0F, 64'hAAAAAAAABBBBBBBB, 2'd0);
        m_put(idx(2, 1), 8'h0F, 64'hAAAAAAAABBBBBBBB);
        take(b, t, d, id);
        acq(26'd2, 3'd1, 3'd0, 1, 8'h00, 64'd0, 2'd3);
        take(b, t, d, id);
        tests++;
        if (d !== 64'h11223344BBBBBBBB) begin
            fails++; $display("FAIL get_masked got %h required 11223344bbbbbbbb", d);
        end
        for (int k = 0; k < 20; k++) begin
            logic [25:0] blk = 26'($urandom);
            logic [2:0] bt = 3'($urandom);
            logic [7:0] m = k < 4 ? 8'hFF : 8'($urandom);
            logic [63:0] wd = {$urandom, $urandom};
            logic [1:0] xid = 2'($urandom);
            if (blk[2:0] == 3'd2 && bt == 3'd1) bt = 3'd2;
            if (k >= 4) begin
                acq(blk, bt, 3'd2, 1, 8'hFF, {$urandom, $urandom}, xid);
                m_put(idx(blk, bt), 8'hFF, a_data);
                take(b, t, d, id);
            end
            acq(blk, bt, 3'd2, 1, m, wd, xid);
            m_put(idx(blk, bt), m, wd);
            take(b, t, d, id);
            tests++;
            if ({t, b, id, d} !== {4'd3, 3'd0, xid, 64'd0}) begin
                fails++; $display("FAIL rand_ack got t=%0d b=%0d id=%0d d=%h required 3 0 %0d 0", t, b, id, d, xid);
            end
            acq(blk ^ (26'($urandom) << 3), bt, 3'd0, 1, 8'h00, 64'd0, ~xid);
            take(b, t, d, id);
            tests++;
            if ({t, b, id, d} !== {4'd4, bt, ~xid, mem_m[idx(blk, bt)]}) begin
                fails++; $display("FAIL rand_get got t=%0d b=%0d id=%0d d=%h required 4 %0d %0d %h",
                                  t, b, id, d, bt, ~xid, mem_m[idx(blk, bt)]);
            end
        end
    endtask

    task automatic test_put_block_get_block;
        logic [2:0] b; logic [3:0] t; logic [63:0] d; logic [1:0] id;
        for (int k = 0; k < 8; k++) begin
            acq(k == 0 ? 26'd5 : 26'($urandom), 3'(k), 3'd3, 1, 8'hFF, 64'(k * 32'h0101),
                k == 0 ? 2'd1 : 2'($urandom));
            m_put(idx(5, 3'(k)), 8'hFF, 64'(k * 32'h0101));
            if (k < 7) begin
                tests++;
                if (g_valid !== 1'b0 || a_ready !== 1'b1) begin
                    fails++; $display("FAIL putblk_mid%0d got valid=%b ready=%b required 0 1", k, g_valid, a_ready);
                end
            end
        end
        take(b, t, d, id);
        tests++;
        if ({t, id, d} !== {4'd3, 2'd1, 64'd0}) begin
            fails++; $display("FAIL putblk_ack got t=%0d id=%0d d=%h required 3 1 0", t, id, d);
        end
        acq(26'd5, 3'd0, 3'd1, 1, 8'h00, 64'd0, 2'd2);
        g_ready = 1;
        for (int k = 0; k < 8; k++) begin
            tests++;
            if ({g_valid, g_type, g_beat, g_id, g_data} !== {1'b1, 4'd5, 3'(k), 2'd2, 64'(k * 32'h0101)}) begin
                fails++; $display("FAIL getblk_beat%0d got v=%b t=%0d b=%0d id=%0d d=%h required 1 5 %0d 2 %h",
                                  k, g_valid, g_type, g_beat, g_id, g_data, k, 64'(k * 32'h0101));
            end
            @(negedge clk);
        end
        g_ready = 0;
        tests++;
        if (a_ready !== 1'b1 || g_valid !== 1'b0) begin
            fails++; $display("FAIL getblk_end got ready=%b valid=%b required 1 0", a_ready, g_valid);
        end
    endtask

    task automatic test_stall;
        logic [2:0] pb = 0; logic [3:0] pt = 0; logic [63:0] pd = 0;
        logic [2:0] b; logic [3:0] t; logic [63:0] d; logic [1:0] id;
        bit stalled = 0;
        int fires = 0, c = 0;
        for (int k = 0; k < 8; k++) begin
            logic [63:0] wd = {$urandom, $urandom};
            acq(26'd3, 3'(k), 3'd3, 1, 8'hFF, wd, 2'd0);
            m_put(idx(3, 3'(k)), 8'hFF, wd);
        end
        take(b, t, d, id);
        acq(26'd11, 3'd0, 3'd1, 1, 8'h00, 64'd0, 2'd3);
        while (fires < 8 && c < 40) begin
            if (g_valid) begin
                if (stalled) begin
                    tests++;
                    if ({g_beat, g_type, g_data} !== {pb, pt, pd}) begin
                        fails++; $display("FAIL stall_hold got b=%0d d=%h required %0d %h", g_beat, g_data, pb, pd);
                    end
                end
                g_ready = c[0];
                if (g_ready) begin
                    tests++;
                    if ({g_beat, g_type, g_data} !== {3'(fires), 4'd5, mem_m[idx(3, 3'(fires))]}) begin
                        fails++; $display("FAIL stall_fire%0d got b=%0d t=%0d d=%h required %0d 5 %h",
                                          fires, g_beat, g_type, g_data, fires, mem_m[idx(3, 3'(fires))]);
                    end
                    fires++;
                end
                stalled = !g_ready;
                pb = g_beat; pt = g_type; pd = g_data;
            end
            @(negedge clk);
            c++;
        end
        g_ready = 0;
        tests++;
        if (fires != 8 || a_ready !== 1'b1 || g_valid !== 1'b0) begin
            fails++; $display("FAIL stall_end got fires=%0d ready=%b valid=%b required 8 1 0", fires, a_ready, g_valid);
        end
    endtask

    task automatic test_misc;
        logic [2:0] b; logic [3:0] t; logic [63:0] d; logic [1:0] id;
        acq(26'd2, 3'd1, 3'd5, 1, 8'hFF, 64'hDEAD, 2'd1);
        repeat (3) begin
            tests++;
            if (a_ready !== 1'b0 || g_valid !== 1'b1 || g_type !== 4'd1) begin
                fails++; $display("FAIL prefetch_pending got ready=%b valid=%b t=%0d required 0 1 1", a_ready, g_valid, g_type);
            end
            @(negedge clk);
        end
        take(b, t, d, id);
        acq(26'd2, 3'd1, 3'd2, 0, 8'hFF, 64'hBEEF, 2'd2);
        take(b, t, d, id);
        tests++;
        if ({t, d} !== {4'd4, 64'd0}) begin
            fails++; $display("FAIL nonbuiltin got t=%0d d=%h required 4 0", t, d);
        end
        acq(26'd2, 3'd1, 3'd4, 1, 8'hFF, 64'hF00D, 2'd0);
        take(b, t, d, id);
        tests++;
        if (t !== 4'd3) begin fails++; $display("FAIL atomic_ack got t=%0d required 3", t); end
        acq(26'd2, 3'd1, 3'd0, 1, 8'h00, 64'd0, 2'd0);
        take(b, t, d, id);
        tests++;
        if (d !== mem_m[idx(2, 1)]) begin
            fails++; $display("FAIL misc_unchanged got %h required %h", d, mem_m[idx(2, 1)]);
        end
    endtask

    task automatic test_reset_mid;
        logic [2:0] b; logic [3:0] t; logic [63:0] d; logic [1:0] id;
        acq(26'd6, 3'd0, 3'd3, 1, 8'hFF, 64'h6060, 2'd0);
        acq(26'd6, 3'd1, 3'd3, 1, 8'hFF, 64'h6161, 2'd0);
        m_put(idx(6, 0), 8'hFF, 64'h6060);
        m_put(idx(6, 1), 8'hFF, 64'h6161);
        reset = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        acq(26'd6, 3'd1, 3'd0, 1, 8'h00, 64'd0, 2'd0);
        take(b, t, d, id);
        tests++;
        if (d !== 64'h6161) begin fails++; $display("FAIL partial_putblk got %h required 6161", d); end
        acq(26'd5, 3'd0, 3'd1, 1, 8'h00, 64'd0, 2'd1);
        g_ready = 1;
        repeat (3) @(negedge clk);
        g_ready = 0;
        tests++;
        if (g_valid !== 1'b1 || g_beat !== 3'd3) begin
            fails++; $display("FAIL mid_beat got valid=%b b=%0d required 1 3", g_valid, g_beat);
        end
        reset = 0;
        #1;
        tests++;
        if (g_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_valid got %b required 0", g_valid); end
        @(negedge clk);
        reset = 1;
        #1;
        tests++;
        if (a_ready !== 1'b1 || g_valid !== 1'b0) begin
            fails++; $display("FAIL mid_release got ready=%b valid=%b required 1 0", a_ready, g_valid);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_put_get();
        test_put_block_get_block();
        test_stall();
        test_misc();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mmio_tile_link_responder.md
Name: mmio_tile_link_responder

Overview:
- Outer-side TileLink MMIO slave: the responder that terminates the outer acquire channel issued by the MMIO tile-link manager.
- Answers with grants on the outer grant channel.
- Backs accesses with an internal 64-bit-word scratch register array.
- Handles built-in Get, GetBlock, Put and PutBlock, one transaction at a time; used as the default MMIO endpoint and as a loopback target for manager bring-up.

Parameters:
ADDR_BITS, 6, log2 of array depth in 64-bit words; word index = {addr_block[ADDR_BITS-4:0], addr_beat}; ADDR_BITS >= 4
MANAGER_ID, 0, constant driven on grant manager_xact_id

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
io_acquire_ready  out  1  acquire beat accepted when ready & valid
io_acquire_valid  in  1  acquire beat valid
io_acquire_bits_addr_block  in  26  block address
io_acquire_bits_client_xact_id  in  2  manager-side transaction id, echoed on grant
io_acquire_bits_addr_beat  in  3  beat index within block
io_acquire_bits_is_builtin_type  in  1  built-in acquire flag
io_acquire_bits_a_type  in  3  0 Get, 1 GetBlock, 2 Put, 3 PutBlock, 4 PutAtomic, 5 GetPrefetch, 6 PutPrefetch
io_acquire_bits_union  in  12  union[8:1] = byte write mask for Put/PutBlock
io_acquire_bits_data  in  64  write data
io_grant_ready  in  1  grant beat consumed when ready & valid
io_grant_valid  out  1  grant beat valid
io_grant_bits_addr_beat  out  3  beat index
io_grant_bits_client_xact_id  out  2  echo of latched acquire client_xact_id
io_grant_bits_manager_xact_id  out  1  MANAGER_ID
io_grant_bits_is_builtin_type  out  1  always 1
io_grant_bits_g_type  out  4  1 prefetchAck, 3 putAck, 4 getDataBeat, 5 getDataBlock
io_grant_bits_data  out  64  read data; 0 for acks

Behaviour:
- Reset (reset low, async):
  - state IDLE; io_grant_valid 0; all grant bits 0.
  - io_acquire_ready is 1 once reset is released.
  - Array contents are not reset.
- FSM states: IDLE, PUT_BLK, GRANT, GET_BLK.
- io_acquire_ready = 1 in IDLE and PUT_BLK, 0 in GRANT and GET_BLK. io_grant_valid = 1 only in GRANT and GET_BLK.
- IDLE, on acquire fire: latch client_xact_id, addr_block and type.
  - Get: read word at index; load grant register with g_type 4, addr_beat = acquire addr_beat, data = word; go GRANT. The grant is visible the cycle after the accept (1-cycle latency).
  - GetBlock: load beat 0 data, g_type 5, addr_beat 0; go GET_BLK.
  - Put: byte-masked write of data into word at index on the accept edge (mask bit i enables byte i); load putAck (g_type 3, data 0, addr_beat 0); go GRANT.
  - PutBlock:
    - Beat 0 written on accept; go PUT_BLK.
    - If the first beat carries addr_beat 7, behave as Put: single beat, putAck.
  - PutAtomic: no write; putAck; go GRANT.
  - GetPrefetch/PutPrefetch: no access; g_type 1; go GRANT.
  - Non-built-in acquire: no access; g_type 4, data 0; go GRANT.
- PUT_BLK:
  - Each fired beat is written at its own addr_beat, masked.
  - The beat with addr_beat 7 loads putAck and moves to GRANT.
  - addr_block/xact id of continuation beats are ignored; the latched values are used.
- GRANT: hold all grant bits stable while io_grant_valid & !io_grant_ready. On grant fire go IDLE; a new acquire can be accepted the following cycle.
- GET_BLK:
  - On each grant fire with beat < 7: increment beat, load next word. Back-to-back beats with grant_ready held 1, 8 beats in 8 cycles.
  - Fire on beat 7 returns to IDLE.
  - Bits stay stable while stalled.
- Index wraps: upper addr_block bits above ADDR_BITS-4 are ignored (aliasing).
- No simultaneous acquire accept and grant issue: ready/valid are mutually exclusive by state.
- Reset asserted mid-transaction aborts it: grant_valid drops immediately, partial PutBlock writes remain.

Test Plan:
1. Put block 2 beat 1, data 0x1122334455667788, mask 0xFF, xact id 2 -> next cycle grant valid, g_type 3, client_xact_id 2, data 0. Then Get same address -> g_type 4, data 0x1122334455667788.
2. Put mask 0x0F with data 0xAAAAAAAABBBBBBBB over the word from scenario 1 -> subsequent Get returns 0x11223344BBBBBBBB.
3. PutBlock block 5, beats 0..7 data = beat*0x0101 -> single putAck after beat 7 only. GetBlock block 5 with grant_ready constantly 1 -> 8 consecutive beats, addr_beat 0..7, data matching, then acquire_ready returns 1.
4. GetBlock with grant_ready toggling 1/0 -> every beat held stable while stalled, exactly 8 fires, no beat skipped or repeated.
5. GetPrefetch and non-built-in acquire -> g_type 1 and g_type 4/data 0 respectively, array unchanged. acquire_ready stays 0 while the grant is pending.
6. Assert reset low mid-GET_BLK at beat 3 -> grant_valid 0 the same cycle. After release, state IDLE, acquire_ready 1.
